// File: rtl/magia_sync_node.sv
// Hardware barrier node: collects per-tile rising-edge arrivals at a common level and releases all tiles together.
// Optional barrier timeout flag is built only when MAGIA_SYNC_NODE_TIMEOUT_EN is defined.
module magia_sync_node #(
  parameter int unsigned N_TILES        = 4,
  parameter int unsigned LVL_WIDTH      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_TILES-1:0]             sync_req_i,
  input  logic [N_TILES*LVL_WIDTH-1:0]   sync_lvl_i,
  output logic [N_TILES-1:0]             sync_ack_o,
  output logic [N_TILES-1:0]             sync_err_o,
  output logic [N_TILES-1:0]             arrived_o,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [N_TILES-1:0] ALL_ONES = {N_TILES{1'b1}};

  logic [1:0]           state_q, state_d;
  logic [N_TILES-1:0]   req_q;
  logic [N_TILES-1:0]   mask_q, mask_d;
  logic [N_TILES-1:0]   ack_q, ack_d;
  logic [N_TILES-1:0]   err_q, err_d;
  logic [LVL_WIDTH-1:0] lvl_q, lvl_d;

  logic [N_TILES-1:0]   arrive;
  logic [N_TILES-1:0]   base_mask;
  logic [N_TILES-1:0]   new_arr;
  logic [N_TILES-1:0]   match;
  logic [N_TILES-1:0]   mask_next;
  logic [LVL_WIDTH-1:0] first_lvl;
  logic [LVL_WIDTH-1:0] ref_lvl;
  logic [LVL_WIDTH-1:0] tile_lvl [N_TILES];
  logic                 in_collect;

  assign arrive     = sync_req_i & ~req_q;
  assign in_collect = (state_q == ST_COLLECT);

  always_comb begin
    for (int k = 0; k < N_TILES; k++) begin
      tile_lvl[k] = sync_lvl_i[k*LVL_WIDTH +: LVL_WIDTH];
    end
  end

  // Level of the lowest-index tile arriving this cycle; opens a new barrier.
  always_comb begin
    first_lvl = '0;
    for (int k = N_TILES - 1; k >= 0; k--) begin
      if (arrive[k]) first_lvl = tile_lvl[k];
    end
  end

  // Outside COLLECT the mask is empty and the reference level comes from this
  // cycle's arrivals, so IDLE and RELEASE open a barrier the same way.
  always_comb begin
    ref_lvl   = in_collect ? lvl_q : first_lvl;
    base_mask = in_collect ? mask_q : '0;
    new_arr   = arrive & ~base_mask;
    for (int k = 0; k < N_TILES; k++) begin
      match[k] = (tile_lvl[k] == ref_lvl);
    end
    mask_next = base_mask | (new_arr & match);
  end

  always_comb begin
    state_d = ST_IDLE;
    mask_d  = '0;
    lvl_d   = lvl_q;
    err_d   = new_arr & ~match;
    if (!in_collect && (arrive != '0)) lvl_d = first_lvl;
    if (mask_next == ALL_ONES) begin
      state_d = ST_RELEASE;
      mask_d  = '0;
    end else if (mask_next != '0) begin
      state_d = ST_COLLECT;
      mask_d  = mask_next;
    end
    ack_d = (state_d == ST_RELEASE) ? ALL_ONES : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      mask_q  <= '0;
      lvl_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= sync_req_i;
      mask_q  <= mask_d;
      lvl_q   <= lvl_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign sync_ack_o = ack_q;
  assign sync_err_o = err_q;
  assign arrived_o  = mask_q;
  assign busy_o     = in_collect;

`ifdef MAGIA_SYNC_NODE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // Counts COLLECT cycles; the flag is set during the TIMEOUT_CYCLES-th one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (in_collect) begin
      if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_magia_sync_node.sv
// Directed bench for magia_sync_node: stimulus pushes expected ack/err pulses, a monitor pops and compares them.
// Arrival mask, busy and timeout are checked directly at fixed cycles.
module tb_magia_sync_node;

  localparam int unsigned N_TILES = 4;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lvl;
  logic [3:0] sync_ack_o;
  logic [3:0] sync_err_o;
  logic [3:0] arrived_o;
  logic       busy_o;
  logic       timeout_o;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  magia_sync_node #(
    .N_TILES(N_TILES),
    .LVL_WIDTH(1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sync_req_i(req),
    .sync_lvl_i(lvl),
    .sync_ack_o(sync_ack_o),
    .sync_err_o(sync_err_o),
    .arrived_o(arrived_o),
    .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  // scoreboard: {cycle[15:0], ack[3:0], err[3:0]}
  logic [23:0] exp_q[$];
  logic [23:0] mon_got;
  logic [23:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_out(input int c, input logic [3:0] a, input logic [3:0] e);
    logic [15:0] c16;
    c16 = c[15:0];
    exp_q.push_back({c16, a, e});
  endtask

  // driver helpers: at(c) returns 1 time unit after the posedge that starts cycle c
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_status(input string name, input logic [3:0] arr, input logic bsy);
    @(negedge clk);
    check({name, "_arrived"}, {28'd0, arrived_o}, {28'd0, arr});
    check({name, "_busy"}, {31'd0, busy_o}, {31'd0, bsy});
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst && ((sync_ack_o | sync_err_o) != 4'd0)) begin
      mon_got = {cyc[15:0], sync_ack_o, sync_err_o};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got cycle %0d ack %b err %b, expected nothing", cyc, sync_ack_o, sync_err_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("ack_err_out", {8'd0, mon_got}, {8'd0, mon_exp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  int b;

  initial begin
    rst = 1'b1;
    req = 4'd0;
    lvl = 4'd0;

    // reset state
    at(2);
    @(negedge clk);
    check("rst_ack", {28'd0, sync_ack_o}, 32'd0);
    check("rst_err", {28'd0, sync_err_o}, 32'd0);
    check("rst_arrived", {28'd0, arrived_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    at(4);
    rst = 1'b0;

    // staggered arrivals at 10,12,15,20 -> ack at 21, busy 11..20
    b = 10;
    at(b);
    req[0] = 1'b1;
    expect_out(b + 11, 4'b1111, 4'b0000);
    check_status("t1_c10", 4'b0000, 1'b0);
    at(b + 1);  check_status("t1_c11", 4'b0001, 1'b1);
    at(b + 2);  req[1] = 1'b1;
    at(b + 3);  check_status("t1_c13", 4'b0011, 1'b1);
    at(b + 5);  req[2] = 1'b1;
    at(b + 10); req[3] = 1'b1;
    check_status("t1_c20", 4'b0111, 1'b1);
    at(b + 11); req = 4'd0;
    check_status("t1_c21", 4'b0000, 1'b0);
    at(b + 12); check_status("t1_c22", 4'b0000, 1'b0);

    // all tiles in one cycle -> ack next cycle, never busy
    b = 30;
    at(b);
    req = 4'b1111;
    expect_out(b + 1, 4'b1111, 4'b0000);
    check_status("t2_c0", 4'b0000, 1'b0);
    at(b + 1); req = 4'd0;
    check_status("t2_c1", 4'b0000, 1'b0);
    at(b + 2); check_status("t2_c2", 4'b0000, 1'b0);

    // level mismatch from tile 2
    b = 40;
    at(b);
    req[0] = 1'b1;
    at(b + 3);
    lvl[2] = 1'b1;
    req[2] = 1'b1;
    expect_out(b + 4, 4'b0000, 4'b0100);
    at(b + 4); check_status("t3_c4", 4'b0001, 1'b1);
    at(b + 6); check_status("t3_c6", 4'b0001, 1'b1);
    at(b + 7); rst = 1'b1; req = 4'd0; lvl = 4'd0;
    at(b + 8); rst = 1'b0;
    check_status("t3_after_rst", 4'b0000, 1'b0);

    // reset during COLLECT discards arrivals
    b = 55;
    at(b);
    req = 4'b0111;
    at(b + 1); check_status("t4_c1", 4'b0111, 1'b1);
    rst = 1'b1; req = 4'd0;
    at(b + 2); rst = 1'b0;
    check_status("t4_c2", 4'b0000, 1'b0);
    at(b + 3); req[3] = 1'b1;
    at(b + 4); check_status("t4_c4", 4'b1000, 1'b1);
    at(b + 8); check_status("t4_c8", 4'b1000, 1'b1);
    rst = 1'b1; req = 4'd0;
    at(b + 9); rst = 1'b0;

    // request held through reset arrives right after reset
    b = 70;
    at(b);
    req[0] = 1'b1;
    rst = 1'b1;
    at(b + 1); rst = 1'b0;
    check_status("t5_c1", 4'b0000, 1'b0);
    at(b + 2); check_status("t5_c2", 4'b0001, 1'b1);
    rst = 1'b1; req = 4'd0;
    at(b + 3); rst = 1'b0;

    // arrival in RELEASE opens a new barrier; repeated edge is ignored
    b = 80;
    at(b);
    req[1] = 1'b1;
    at(b + 1);
    req = 4'b1101;
    expect_out(b + 2, 4'b1111, 4'b0000);
    at(b + 2); req = 4'b0010;
    check_status("t6_release", 4'b0000, 1'b0);
    at(b + 3); check_status("t6_c3", 4'b0010, 1'b1);
    at(b + 4); req = 4'd0;
    at(b + 5); req = 4'b0010;
    at(b + 6); check_status("t6_repeat", 4'b0010, 1'b1);
`ifdef MAGIA_SYNC_NODE_TIMEOUT_EN
    at(b + 18); @(negedge clk); check("t6_timeout_before", {31'd0, timeout_o}, 32'd0);
    at(b + 19); @(negedge clk); check("t6_timeout_rise", {31'd0, timeout_o}, 32'd1);
    at(b + 25); @(negedge clk); check("t6_timeout_sticky", {31'd0, timeout_o}, 32'd1);
`else
    at(b + 19); @(negedge clk); check("t6_timeout_off", {31'd0, timeout_o}, 32'd0);
    at(b + 25); @(negedge clk); check("t6_timeout_off_late", {31'd0, timeout_o}, 32'd0);
`endif
    rst = 1'b1; req = 4'd0;
    at(b + 26); rst = 1'b0;
    @(negedge clk); check("t6_timeout_cleared", {31'd0, timeout_o}, 32'd0);

    // same-cycle arrivals in IDLE with mixed levels; lowest tile sets level 1
    b = 110;
    at(b);
    lvl = 4'b1001;
    req = 4'b1011;
    expect_out(b + 1, 4'b0000, 4'b0010);
    at(b + 1); check_status("t7_c1", 4'b1001, 1'b1);
    at(b + 2); lvl[2] = 1'b1; req[2] = 1'b1;
    at(b + 3); req[1] = 1'b0;
    check_status("t7_c3", 4'b1101, 1'b1);
    at(b + 4); lvl[1] = 1'b1; req[1] = 1'b1;
    expect_out(b + 5, 4'b1111, 4'b0000);
    at(b + 5); req = 4'd0; lvl = 4'd0;
    check_status("t7_c5", 4'b0000, 1'b0);

    at(b + 8);
    @(negedge clk);
    check("pending_expected", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
